// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: latches a 2-digit BCD value and scans it onto a common-anode 7-seg display (option: LEADING_ZERO_BLANK_EN)
module bcd_display_scanner #(
  parameter int REFRESH_DIV = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       load,
  input  logic [3:0] tens_in,
  input  logic [3:0] ones_in,
  output logic [6:0] seg_n,
  output logic [1:0] an_n,
  output logic       frame_done
);
  localparam int RG   = REFRESH_DIV > GAP_CYCLES ? REFRESH_DIV : GAP_CYCLES;
  localparam int MAXN = RG > 2 ? RG : 2;
  localparam int CW   = $clog2(MAXN);
  typedef enum logic [1:0] {SCAN_ONES, GAP_ONES, SCAN_TENS, GAP_TENS} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [3:0] tens, ones;
  logic last, tens_lit, fd_nx;
  logic [6:0] seg_nx;
  logic [1:0] an_nx;
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0: decode = 7'h40;
      4'd1: decode = 7'h79;
      4'd2: decode = 7'h24;
      4'd3: decode = 7'h30;
      4'd4: decode = 7'h19;
      4'd5: decode = 7'h12;
      4'd6: decode = 7'h02;
      4'd7: decode = 7'h78;
      4'd8: decode = 7'h00;
      4'd9: decode = 7'h10;
      default: decode = 7'h3F;
    endcase
  endfunction
  // next state, dwell-end detection and the registered-output values for this state
  always_comb begin
    last = (state == SCAN_ONES || state == SCAN_TENS) ? cnt == CW'(REFRESH_DIV - 1)
                                                      : cnt == CW'(GAP_CYCLES - 1);
    state_nx = !last ? state :
               state == SCAN_ONES ? (GAP_CYCLES == 0 ? SCAN_TENS : GAP_ONES) :
               state == GAP_ONES  ? SCAN_TENS :
               state == SCAN_TENS ? (GAP_CYCLES == 0 ? SCAN_ONES : GAP_TENS) : SCAN_ONES;
`ifdef LEADING_ZERO_BLANK_EN
    tens_lit = state == SCAN_TENS && tens != 4'd0;
`else
    tens_lit = state == SCAN_TENS;
`endif
    an_nx  = state == SCAN_ONES ? 2'b10 : tens_lit ? 2'b01 : 2'b11;
    seg_nx = state == SCAN_ONES ? decode(ones) : tens_lit ? decode(tens) : 7'h7F;
    fd_nx  = last && state == (GAP_CYCLES == 0 ? SCAN_TENS : GAP_TENS);
  end
  // state, dwell counter (cleared on every transition), digit capture and output registers
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state      <= SCAN_ONES;
      cnt        <= '0;
      tens       <= '0;
      ones       <= '0;
      seg_n      <= 7'h7F;
      an_n       <= 2'b11;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= last ? '0 : cnt + 1'b1;
      tens       <= load ? tens_in : tens;
      ones       <= load ? ones_in : ones;
      seg_n      <= seg_nx;
      an_n       <= an_nx;
      frame_done <= fd_nx;
    end
  end
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: directed checks of scan order, capture, decode, reset and no-gap scanning
module tb_bcd_display_scanner;
  logic Clock = 1'b0;
  logic Resetn, load;
  logic [3:0] tens_in, ones_in;
  logic [6:0] seg1, seg2;
  logic [1:0] an1, an2;
  logic fd1, fd2;
  int n, vec, errs;
  bcd_display_scanner #(.REFRESH_DIV(4), .GAP_CYCLES(1)) dut1 (
    .Clock(Clock), .Resetn(Resetn), .load(load), .tens_in(tens_in), .ones_in(ones_in),
    .seg_n(seg1), .an_n(an1), .frame_done(fd1));
  bcd_display_scanner #(.REFRESH_DIV(2), .GAP_CYCLES(0)) dut2 (
    .Clock(Clock), .Resetn(Resetn), .load(load), .tens_in(tens_in), .ones_in(ones_in),
    .seg_n(seg2), .an_n(an2), .frame_done(fd2));
  always #5 Clock = ~Clock;
  task automatic step();
    @(posedge Clock);
    #1;
    n++;
  endtask
  task automatic test_reset();
    Resetn = 1'b0; load = 1'b0; tens_in = '0; ones_in = '0;
    #12;
    vec++; if (seg1 !== 7'h7F || an1 !== 2'b11 || fd1 !== 1'b0) begin errs++; $display("FAIL reset dut1: seg=%h an=%b fd=%b expected seg=7f an=11 fd=0", seg1, an1, fd1); end
    vec++; if (seg2 !== 7'h7F || an2 !== 2'b11 || fd2 !== 1'b0) begin errs++; $display("FAIL reset dut2: seg=%h an=%b fd=%b expected seg=7f an=11 fd=0", seg2, an2, fd2); end
    @(negedge Clock);
    Resetn = 1'b1;
    n = 0;
  endtask
  task automatic test_scan_idle();
    int p, p2;
    logic [1:0] ea, ea2;
    logic [6:0] es;
    for (int i = 0; i < 24; i++) begin
      step();
      p  = (n - 1) % 10;
      p2 = (n - 1) % 4;
      ea  = p < 4 ? 2'b10 : (p == 4 || p == 9) ? 2'b11 : 2'b01;
      es  = ea == 2'b11 ? 7'h7F : 7'h40;
      ea2 = p2 < 2 ? 2'b10 : 2'b01;
      vec++; if (an1 !== ea) begin errs++; $display("FAIL idle_an n=%0d: got %b expected %b", n, an1, ea); end
      vec++; if (seg1 !== es) begin errs++; $display("FAIL idle_seg n=%0d: got %h expected %h", n, seg1, es); end
      vec++; if (fd1 !== (n % 10 == 0)) begin errs++; $display("FAIL idle_fd n=%0d: got %b expected %b", n, fd1, n % 10 == 0); end
      vec++; if (an2 !== ea2 || seg2 !== 7'h40) begin errs++; $display("FAIL nogap_idle n=%0d: an=%b seg=%h expected an=%b seg=40", n, an2, seg2, ea2); end
      vec++; if (fd2 !== (n % 4 == 0)) begin errs++; $display("FAIL nogap_fd n=%0d: got %b expected %b", n, fd2, n % 4 == 0); end
    end
  endtask
  task automatic test_load();
    while (n % 10 != 0) step();
    load = 1'b1; tens_in = 4'd1; ones_in = 4'd7;
    step();
    load = 1'b0;
    vec++; if (seg1 !== 7'h40 || an1 !== 2'b10) begin errs++; $display("FAIL load_latency: seg=%h an=%b expected seg=40 an=10", seg1, an1); end
    step();
    vec++; if (seg1 !== 7'h78 || an1 !== 2'b10) begin errs++; $display("FAIL load_ones: seg=%h an=%b expected seg=78 an=10", seg1, an1); end
    while (n < 35) step();
    for (int k = 0; k < 4; k++) begin
      step();
      vec++; if (seg1 !== 7'h79 || an1 !== 2'b01) begin errs++; $display("FAIL load_tens n=%0d: seg=%h an=%b expected seg=79 an=01", n, seg1, an1); end
    end
    step();
    vec++; if (seg1 !== 7'h7F || an1 !== 2'b11 || fd1 !== 1'b1) begin errs++; $display("FAIL load_gap: seg=%h an=%b fd=%b expected seg=7f an=11 fd=1", seg1, an1, fd1); end
  endtask
  task automatic test_invalid();
    load = 1'b1; tens_in = 4'd3; ones_in = 4'd12;
    step();
    load = 1'b0;
    vec++; if (seg1 !== 7'h78) begin errs++; $display("FAIL invalid_latency: got %h expected 78", seg1); end
    for (int k = 0; k < 3; k++) begin
      step();
      vec++; if (seg1 !== 7'h3F || an1 !== 2'b10) begin errs++; $display("FAIL invalid_ones n=%0d: seg=%h an=%b expected seg=3f an=10", n, seg1, an1); end
    end
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      vec++; if (seg1 !== 7'h30 || an1 !== 2'b01) begin errs++; $display("FAIL invalid_tens n=%0d: seg=%h an=%b expected seg=30 an=01", n, seg1, an1); end
    end
  endtask
  task automatic test_no_gap();
    int p2;
    for (int k = 0; k < 8; k++) begin
      step();
      p2 = (n - 1) % 4;
      vec++; if (an2 !== (p2 < 2 ? 2'b10 : 2'b01) || seg2 !== (p2 < 2 ? 7'h3F : 7'h30)) begin errs++; $display("FAIL nogap_scan n=%0d: an=%b seg=%h expected an=%b seg=%h", n, an2, seg2, p2 < 2 ? 2'b10 : 2'b01, p2 < 2 ? 7'h3F : 7'h30); end
      vec++; if (fd2 !== (n % 4 == 0)) begin errs++; $display("FAIL nogap_frame n=%0d: got %b expected %b", n, fd2, n % 4 == 0); end
    end
  endtask
  task automatic test_reset_mid();
    while (n < 66) step();
    vec++; if (an1 !== 2'b01 || seg1 !== 7'h30) begin errs++; $display("FAIL pre_reset: an=%b seg=%h expected an=01 seg=30", an1, seg1); end
    #2 Resetn = 1'b0;
    #1;
    vec++; if (seg1 !== 7'h7F || an1 !== 2'b11 || fd1 !== 1'b0) begin errs++; $display("FAIL async_reset: seg=%h an=%b fd=%b expected seg=7f an=11 fd=0", seg1, an1, fd1); end
    @(negedge Clock);
    Resetn = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      vec++; if (fd1 !== (n == 10)) begin errs++; $display("FAIL restart_fd n=%0d: got %b expected %b", n, fd1, n == 10); end
      if (n == 1) begin
        vec++; if (an1 !== 2'b10 || seg1 !== 7'h40) begin errs++; $display("FAIL restart_first: an=%b seg=%h expected an=10 seg=40", an1, seg1); end
      end
    end
  endtask
  task automatic test_lzb();
    logic [1:0] ea;
    logic [6:0] es;
`ifdef LEADING_ZERO_BLANK_EN
    ea = 2'b11; es = 7'h7F;
`else
    ea = 2'b01; es = 7'h40;
`endif
    load = 1'b1; tens_in = 4'd0; ones_in = 4'd5;
    step();
    load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      vec++; if (seg1 !== 7'h12 || an1 !== 2'b10) begin errs++; $display("FAIL lzb_ones n=%0d: seg=%h an=%b expected seg=12 an=10", n, seg1, an1); end
    end
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      vec++; if (seg1 !== es || an1 !== ea) begin errs++; $display("FAIL lzb_tens n=%0d: seg=%h an=%b expected seg=%h an=%b", n, seg1, an1, es, ea); end
    end
    step();
    vec++; if (fd1 !== 1'b1) begin errs++; $display("FAIL lzb_fd: got %b expected 1", fd1); end
  endtask
  task automatic test_back_to_back();
    load = 1'b1; tens_in = 4'd9; ones_in = 4'd8;
    step();
    tens_in = 4'd4; ones_in = 4'd6;
    step();
    load = 1'b0;
    vec++; if (seg1 !== 7'h00) begin errs++; $display("FAIL b2b_first: got %h expected 00", seg1); end
    step();
    vec++; if (seg1 !== 7'h02) begin errs++; $display("FAIL b2b_second: got %h expected 02", seg1); end
    while (n < 25) step();
    for (int k = 0; k < 4; k++) begin
      step();
      vec++; if (seg1 !== 7'h19 || an1 !== 2'b01) begin errs++; $display("FAIL b2b_tens n=%0d: seg=%h an=%b expected seg=19 an=01", n, seg1, an1); end
    end
  endtask
  initial begin
    vec = 0; errs = 0; n = 0;
    test_reset();
    test_scan_idle();
    test_load();
    test_invalid();
    test_no_gap();
    test_reset_mid();
    test_lzb();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/bcd_display_scanner.md
Name: bcd_display_scanner

Overview:
Downstream consumer of the BCD converter stage. Captures the two BCD digits it produces (tens and ones) on a load strobe and time-multiplexes them onto a 2-digit common-anode seven-segment display. Provides a refresh counter, an inter-digit ghosting gap, invalid-code indication and a frame-complete pulse. Sits between the binary-to-BCD stage and the board display pins.

Parameters:
REFRESH_DIV, 4, clock cycles each digit is lit per scan; legal range >=2.
GAP_CYCLES, 1, clock cycles both anodes are off after each digit; 0 skips the gap states.

Ports:
Clock    input   1  system clock, rising edge
Resetn   input   1  asynchronous, active-low reset
load     input   1  capture tens_in/ones_in on this rising edge
tens_in  input   4  tens BCD digit
ones_in  input   4  ones BCD digit
seg_n    output  7  active-low segments; bit0=a ... bit6=g
an_n     output  2  active-low anodes; bit0=ones digit, bit1=tens digit
frame_done output 1  one-cycle pulse at the end of each full scan

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low (Resetn).
- Reset state:
  - state=SCAN_ONES, counter=0, digit registers=0.
  - seg_n=7'h7F, an_n=2'b11, frame_done=0.
  - Asserting Resetn mid-scan forces these values immediately, without waiting for a clock edge.
- Capture:
  - load=1 at edge k writes both digit registers at edge k.
  - The new value appears on seg_n at edge k+1 if that digit is currently lit.
  - load is accepted every cycle; there is no busy signal and back-to-back loads are allowed.
- FSM:
  - SCAN_ONES (REFRESH_DIV cycles) -> GAP_ONES (GAP_CYCLES) -> SCAN_TENS (REFRESH_DIV) -> GAP_TENS (GAP_CYCLES) -> SCAN_ONES.
  - If GAP_CYCLES=0, the gap states are bypassed.
  - A single counter, width $clog2(max(REFRESH_DIV, GAP_CYCLES, 2)), runs 0..N-1 and is cleared on every state change.
  - Scan period = 2*(REFRESH_DIV+GAP_CYCLES) cycles.
- Outputs: all registered, computed from current state and digit registers, so they lag state by one cycle.
  - SCAN_ONES: an_n=2'b10, seg_n=decode(ones).
  - SCAN_TENS: an_n=2'b01, seg_n=decode(tens).
  - Gap states: an_n=2'b11, seg_n=7'h7F.
- frame_done: registered; high for exactly one cycle, on the edge after the last cycle of GAP_TENS (or of SCAN_TENS when GAP_CYCLES=0).
- Decode table (seg_n, active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19
  - 5=12, 6=02, 7=78, 8=00, 9=10
  - Codes 10..15 show a dash: 3F (segment g only).
- Simultaneous events: a load on the edge where state changes uses the new digit value for the next lit output. Only the digit registers are affected; counter and state are not.
- Boundary: the counter wraps only through a state change; no overflow is possible for legal parameters.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: during SCAN_TENS, if tens==0 then an_n=2'b11 and seg_n=7'h7F. Timing and frame_done are unchanged.
- Undefined: tens==0 is shown as "0" (seg_n=40).

Test Plan:
- Reset, then run 24 cycles with load=0 (REFRESH_DIV=4, GAP_CYCLES=1):
  - an_n cycles 10 x4, 11 x1, 01 x4, 11 x1.
  - seg_n=40 on both digits.
  - frame_done pulses every 10 cycles.
- load=1 with tens=1, ones=7 during SCAN_ONES -> seg_n=78 on the following edge, and 79 during the next SCAN_TENS window.
- load with ones=12 (invalid) -> seg_n=3F while the ones digit is lit; tens shows its normal value.
- Assert Resetn low mid-SCAN_TENS -> seg_n=7F and an_n=11 immediately. After release, the scan restarts at SCAN_ONES and the first frame_done comes 10 cycles later.
- GAP_CYCLES=0, REFRESH_DIV=2 -> an_n alternates 10,10,01,01 with no 11 cycles; frame_done every 4 cycles.
- With LEADING_ZERO_BLANK_EN defined, load tens=0, ones=5 -> an_n=11 throughout SCAN_TENS and seg_n=12 during SCAN_ONES. Without the macro, the tens slot shows seg_n=40.
